// File: rtl/sram_mem_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// sram_pkg
// Shared types and constants for the SRAM memory-stage controller.
//   state_t          : controller FSM state (IDLE/LOW/HIGH/DONE, 2-bit)
//   SRAM_DATA_W      : external SRAM data bus width (16)
//   DEF_SRAM_ADDR_W  : default SRAM halfword address width (18)
//   DEF_BASE_ADDR    : default CPU byte address mapped to SRAM word 0
//   DEF_WAIT_CYCLES  : default cycles per 16-bit SRAM phase
// ----------------------------------------------------------------------------
package sram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int          SRAM_DATA_W     = 16;
    localparam int          DEF_SRAM_ADDR_W = 18;
    localparam logic [31:0] DEF_BASE_ADDR   = 32'd1024;
    localparam int          DEF_WAIT_CYCLES = 2;

endpackage

// File: rtl/sram_mem_ctrl_wait_counter.sv
// ----------------------------------------------------------------------------
// sram_wait_counter
// 4-bit cycle counter that times one SRAM access phase.
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous, active-high reset (count -> 0)
//   clear  : synchronous clear, wins over enable
//   enable : increment count this cycle
//   last   : count == WAIT_CYCLES-1 (final cycle of the phase)
// WAIT_CYCLES must lie in 1..15 so the final count fits in 4 bits.
// ----------------------------------------------------------------------------
module sram_wait_counter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic last
);

    logic [3:0] count;

    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 4'd1;
        end
    end

    assign last = (count == 4'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_mem_ctrl.sv
// ----------------------------------------------------------------------------
// sram_mem_ctrl
// Memory-stage controller: turns each 32-bit LDR/STR word access into two
// 16-bit SRAM accesses (low half, then high half), each WAIT_CYCLES long,
// and holds ready low for the whole access so the pipeline freezes.
// Ports:
//   clk, rst       : clock (rising edge), synchronous active-high reset
//   mem_read       : load request (held while ready=0)
//   mem_write      : store request (held while ready=0); wins over mem_read
//   address        : CPU byte address
//   write_data     : store data
//   read_data      : load result, changes only on loads
//   ready          : 0 = freeze pipeline
//   sram_addr      : SRAM halfword address {word, half}
//   sram_dq_out    : SRAM write data
//   sram_dq_in     : SRAM read data
//   sram_dq_oe     : 1 = controller drives DQ
//   sram_we_n      : active-low write enable
//   err            : misalignment pulse during DONE
// Build option: define SRAM_ERR_EN to reject accesses with address[1:0]!=0
// (no SRAM cycle, err=1 in DONE). Without it err is tied to 0.
// ----------------------------------------------------------------------------
module sram_mem_ctrl
    import sram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter int          WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int          SRAM_ADDR_W = DEF_SRAM_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [SRAM_DATA_W-1:0] sram_dq_out,
    input  logic [SRAM_DATA_W-1:0] sram_dq_in,
    output logic                   sram_dq_oe,
    output logic                   sram_we_n,
    output logic                   err
);

    state_t state, state_next;

    logic                   req;
    logic                   misaligned;
    logic [31:0]            offset;
    logic [SRAM_ADDR_W-2:0] word_q;
    logic [31:0]            wdata_q;
    logic                   write_q;

    logic accept;
    logic capture_lo;
    logic capture_hi;
    logic cnt_clear;
    logic cnt_en;
    logic cnt_last;

    // Only the word-index bits of the offset reach the SRAM.
    logic unused_bits;
    assign unused_bits = ^{offset[31:SRAM_ADDR_W], offset[1:0], address[1:0]};

    assign req    = mem_read | mem_write;
    assign offset = address - BASE_ADDR;

`ifdef SRAM_ERR_EN
    assign misaligned = (address[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    sram_wait_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .last   (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            read_data <= '0;
            word_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                word_q  <= offset[SRAM_ADDR_W:2];
                wdata_q <= write_data;
                write_q <= mem_write;
            end
            if (capture_lo) read_data[15:0]  <= sram_dq_in;
            if (capture_hi) read_data[31:16] <= sram_dq_in;
        end
    end

`ifdef SRAM_ERR_EN
    // One-cycle pulse: set on the edge into DONE, cleared on the edge out.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else begin
            err <= accept && misaligned;
        end
    end
`else
    assign err = 1'b0;
`endif

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next  = state;
        ready       = 1'b0;
        accept      = 1'b0;
        capture_lo  = 1'b0;
        capture_hi  = 1'b0;
        cnt_clear   = 1'b0;
        cnt_en      = 1'b0;
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;

        case (state)
            IDLE: begin
                ready     = ~req;
                cnt_clear = 1'b1;
                if (req) begin
                    accept     = 1'b1;
                    state_next = misaligned ? DONE : LOW;
                end
            end
            LOW, HIGH: begin
                cnt_en    = 1'b1;
                sram_addr = {word_q, (state == HIGH)};
                if (write_q) begin
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = (state == HIGH) ? wdata_q[31:16] : wdata_q[15:0];
                    // Release WE on the final cycle so data is held across
                    // its rising edge; a single-cycle phase cannot spare one.
                    sram_we_n   = cnt_last && (WAIT_CYCLES > 1);
                end
                if (cnt_last) begin
                    cnt_clear  = 1'b1;
                    capture_lo = ~write_q && (state == LOW);
                    capture_hi = ~write_q && (state == HIGH);
                    state_next = (state == HIGH) ? DONE : HIGH;
                end
            end
            DONE: begin
                ready      = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: doc/sram_mem_ctrl.md
Name: sram_mem_ctrl

Overview:
- Memory-stage controller; consumes the mem_read/mem_write control bits that the decoder emits for LDR/STR.
- Converts each 32-bit word access into two 16-bit accesses to an external SRAM, with programmable wait states.
- Deasserts ready for the whole access so the pipeline freezes.
- Sits between the EX/MEM pipeline register and the SRAM pins.

Parameters:
- BASE_ADDR, 1024: CPU byte address mapped to SRAM word 0.
- WAIT_CYCLES, 2: cycles per 16-bit SRAM access phase; legal range 1..15.
- SRAM_ADDR_W, 18: SRAM address width.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- mem_read  input  1  load request, held stable while ready=0
- mem_write  input  1  store request, held stable while ready=0
- address  input  32  CPU byte address
- write_data  input  32  store data
- read_data  output  32  load result
- ready  output  1  0 = freeze pipeline
- sram_addr  output  SRAM_ADDR_W  SRAM halfword address
- sram_dq_out  output  16  SRAM write data
- sram_dq_in  input  16  SRAM read data
- sram_dq_oe  output  1  1 = controller drives DQ
- sram_we_n  output  1  active-low write enable
- err  output  1  misalignment pulse (only with SRAM_ERR_EN)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, wait counter=0, read_data=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1, err=0.
- Reset mid-access: the next edge aborts the access and returns to IDLE; sram_we_n goes to 1 in that same edge.
- Request: req = mem_read | mem_write. If both are asserted, the access is a write.
- ready (combinational):
  - IDLE: ready = ~req.
  - LOW, HIGH: ready = 0.
  - DONE: ready = 1.
- Address mapping: word = (address - BASE_ADDR) >> 2, computed modulo 2^32. sram_addr = {word[SRAM_ADDR_W-2:0], half}, with half=0 in LOW and half=1 in HIGH. address[1:0] is ignored unless SRAM_ERR_EN is defined.
- State machine:
  - IDLE: if req, latch address, write_data and op, clear the counter, go to LOW. Otherwise stay.
  - LOW: increment the counter each cycle. When counter==WAIT_CYCLES-1: capture sram_dq_in into read_data[15:0] (reads only), clear the counter, go to HIGH.
  - HIGH: same as LOW, but captures into read_data[31:16], then goes to DONE.
  - DONE: go to IDLE unconditionally. Because of this, a held request is not re-triggered.
- Write drive: in LOW/HIGH during a write, sram_dq_oe=1 and sram_dq_out = write_data[15:0] or [31:16] respectively. sram_we_n=0 for every cycle of the phase except the last, and 1 on the last cycle, giving a hold edge. When WAIT_CYCLES=1, sram_we_n=0 for the whole single-cycle phase.
- Read drive: sram_dq_oe=0 and sram_we_n=1 throughout.
- Latency: request seen in cycle 0 gives ready=1 in cycle 2*WAIT_CYCLES+1. With the default, that is cycle 5.
- read_data: updated only by reads; held across writes and idle cycles.
- Back-to-back requests: a new request is accepted in the IDLE cycle after DONE.

Optional Feature:
- Macro: SRAM_ERR_EN.
- Defined: a request with address[1:0]!=0 goes IDLE->DONE directly.
  - No SRAM cycle is issued; sram_we_n stays 1.
  - err=1 for the DONE cycle only.
  - read_data is unchanged.
  - Latency is ready=1 in cycle 1.
- Undefined: no err port logic; err is tied to 0, address[1:0] is ignored, and every request performs the full access.

Decomposition:
- Package sram_pkg holds:
  - state enum IDLE/LOW/HIGH/DONE (2-bit);
  - SRAM_DATA_W=16 and the default SRAM_ADDR_W=18;
  - BASE_ADDR default.
- One sub-module, sram_wait_counter:
  - inputs: clear, enable;
  - output: last, asserted when count==WAIT_CYCLES-1;
  - 4-bit count.

Test Plan:
- Reset check: assert rst for 2 cycles, no request -> ready=1, sram_we_n=1, sram_dq_oe=0, read_data=0.
- Store then load: store write_data=0xDEADBEEF to address=1024 with WAIT_CYCLES=2.
  - Store: ready=0 for cycles 0-4 and 1 in cycle 5; sram_addr=0 with dq=0xBEEF, then sram_addr=1 with dq=0xDEAD; sram_we_n low for exactly 1 cycle per phase.
  - Load from the same address: read_data=0xDEADBEEF in cycle 5.
- Address mapping: load from address=1032, SRAM model returning 0x1234 / 0x5678 -> sram_addr sequence is 4 then 5, read_data=0x56781234.
- Back-to-back with rst mid-write:
  - Two consecutive loads held by the bench -> exactly 2 transactions, second starting in the cycle after the first DONE.
  - rst asserted in LOW of a write -> next cycle state=IDLE, sram_we_n=1.
- Misaligned load (SRAM_ERR_EN defined): load from address=1026 -> err=1 and ready=1 in cycle 1, no SRAM activity, read_data unchanged. Without the macro -> full access at word 0.
